// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB pipeline register for the ARM-subset pipeline.
// Synchronous-read data memory; the write-back triplet feeds the ID register file.
module mem_wb_stage #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dest_in,
  output logic        wb_en_mem,
  output logic [3:0]  dest_mem,
  output logic        write_back,
  output logic [3:0]  dest_wb,
  output logic [31:0] result_wb,
  output logic        addr_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LO = 33'(BASE_ADDR);
  localparam logic [32:0] HI = 33'(BASE_ADDR) + 33'(4 * DEPTH);

  logic [31:0]   mem [DEPTH];

  logic          wb_q,   wb_d;
  logic          rd_q,   rd_d;
  logic [31:0]   alu_q,  alu_d;
  logic [3:0]    dest_q, dest_d;
  logic [31:0]   mem_q,  mem_d;
  logic          err_q,  err_d;

  logic [32:0]   addr_x;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          do_store;
  logic          unused_ok;

  assign wb_en_mem = wb_en_in;
  assign dest_mem  = dest_in;

  // 33-bit compare so the upper bound cannot wrap at the top of the space
  assign addr_x   = {1'b0, alu_result};
  assign in_range = (addr_x >= LO) && (addr_x < HI);
  assign offset   = alu_result - 32'(BASE_ADDR);
  assign idx      = offset[AW+1:2];
  assign do_store = mem_write_in & ~freeze & in_range;

  assign unused_ok = ^{offset[31:AW+2], offset[1:0]};

  always_comb begin
    wb_d   = wb_en_in;
    rd_d   = mem_read_in & ~mem_write_in;
    alu_d  = alu_result;
    dest_d = dest_in;
    mem_d  = in_range ? mem[idx] : 32'h0;
    err_d  = err_q;
    if ((mem_read_in | mem_write_in) & ~in_range)
      err_d = 1'b1;
  end

  // array is not reset; a store while rst is low is dropped
  always_ff @(posedge clk) begin
    if (rst && do_store)
      mem[idx] <= val_rm_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q   <= 1'b0;
      rd_q   <= 1'b0;
      alu_q  <= 32'h0;
      dest_q <= 4'h0;
      mem_q  <= 32'h0;
      err_q  <= 1'b0;
    end else if (!freeze) begin
      wb_q   <= wb_d;
      rd_q   <= rd_d;
      alu_q  <= alu_d;
      dest_q <= dest_d;
      mem_q  <= mem_d;
      err_q  <= err_d;
    end
  end

  assign write_back = wb_q;
  assign dest_wb    = dest_q;
  assign result_wb  = rd_q ? mem_q : alu_q;
  assign addr_err   = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage.
// Driver queues hand-computed write-back triplets; a monitor checks them.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        wb_en_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] val_rm_in = 32'h0;
  logic [3:0]  dest_in = 4'h0;
  logic        wb_en_mem;
  logic [3:0]  dest_mem;
  logic        write_back;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;
  logic        addr_err;

  typedef struct packed {
    logic        wb;
    logic [3:0]  dest;
    logic [31:0] res;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  mem_wb_stage #(.DEPTH(64), .BASE_ADDR(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .wb_en_in     (wb_en_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .alu_result   (alu_result),
    .val_rm_in    (val_rm_in),
    .dest_in      (dest_in),
    .wb_en_mem    (wb_en_mem),
    .dest_mem     (dest_mem),
    .write_back   (write_back),
    .dest_wb      (dest_wb),
    .result_wb    (result_wb),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic issue(input bit frz, input bit wb, input bit rd,
                       input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] ds,
                       input bit ewb, input logic [3:0] eds,
                       input logic [31:0] eres);
    freeze       = frz;
    wb_en_in     = wb;
    mem_read_in  = rd;
    mem_write_in = wr;
    alu_result   = a;
    val_rm_in    = d;
    dest_in      = ds;
    sbq.push_back(exp_t'{ewb, eds, eres});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    freeze       = 1'b0;
    wb_en_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    alu_result   = 32'h0;
    val_rm_in    = 32'h0;
    dest_in      = 4'h0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("write_back", 32'(write_back), 32'(e.wb));
        chk("dest_wb",    32'(dest_wb),    32'(e.dest));
        chk("result_wb",  result_wb,       e.res);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    #1 rst = 1'b0;
    #1;
    chk("rst_write_back", 32'(write_back), 32'h0);
    chk("rst_dest_wb",    32'(dest_wb),    32'h0);
    chk("rst_result_wb",  result_wb,       32'h0);
    chk("rst_addr_err",   32'(addr_err),   32'h0);
    wb_en_in = 1'b1;
    dest_in  = 4'd9;
    #1;
    chk("pass_wb_en_mem", 32'(wb_en_mem), 32'h1);
    chk("pass_dest_mem",  32'(dest_mem),  32'h9);
    idle();

    @(negedge clk);
    rst = 1'b1;
    issue(0, 0, 0, 1, 32'd1024, 32'hDEADBEEF, 4'd0, 0, 4'd0, 32'h400);
    issue(0, 1, 0, 0, 32'h2A,   32'h0,        4'd3, 1, 4'd3, 32'h2A);
    issue(0, 0, 0, 1, 32'd1028, 32'h12345678, 4'd0, 0, 4'd0, 32'h404);
    issue(0, 1, 1, 0, 32'd1028, 32'h0,        4'd5, 1, 4'd5, 32'h12345678);
    issue(0, 1, 1, 0, 32'd1024, 32'h0,        4'd6, 1, 4'd6, 32'hDEADBEEF);
    chk("err_clean", 32'(addr_err), 32'h0);

    issue(0, 0, 0, 1, 32'd1276, 32'hCAFEF00D, 4'd0, 0, 4'd0, 32'h4FC);
    issue(0, 1, 1, 0, 32'd1276, 32'h0,        4'd7, 1, 4'd7, 32'hCAFEF00D);
    chk("err_last_word", 32'(addr_err), 32'h0);
    issue(0, 0, 0, 1, 32'd1280, 32'h55,       4'd0, 0, 4'd0, 32'h500);
    chk("err_store_oob", 32'(addr_err), 32'h1);
    issue(0, 1, 1, 0, 32'd1020, 32'h0,        4'd8, 1, 4'd8, 32'h0);
    chk("err_sticky", 32'(addr_err), 32'h1);
    issue(0, 1, 1, 0, 32'd1024, 32'h0,        4'd9, 1, 4'd9, 32'hDEADBEEF);

    issue(0, 0, 0, 1, 32'd1032, 32'hA5A5A5A5, 4'd0, 0, 4'd0, 32'h408);
    issue(0, 1, 0, 0, 32'h77,   32'h0,        4'd4, 1, 4'd4, 32'h77);
    for (int i = 0; i < 3; i++)
      issue(1, 1, 0, 1, 32'd1032, 32'h5A5A5A5A, 4'd2, 1, 4'd4, 32'h77);
    chk("freeze_mem2", dut.mem[2], 32'hA5A5A5A5);
    issue(0, 1, 0, 1, 32'd1032, 32'h5A5A5A5A, 4'd2, 1, 4'd2, 32'h408);
    issue(0, 1, 1, 0, 32'd1032, 32'h0,        4'd1, 1, 4'd1, 32'h5A5A5A5A);

    issue(0, 0, 0, 1, 32'd1024, 32'h11,       4'd0, 0, 4'd0,  32'h400);
    issue(0, 1, 1, 1, 32'd1024, 32'h22,       4'd10, 1, 4'd10, 32'h400);
    chk("rbw_mem_q", dut.mem_q, 32'h11);
    chk("rbw_mem0",  dut.mem[0], 32'h22);
    issue(0, 1, 1, 0, 32'd1024, 32'h0,        4'd11, 1, 4'd11, 32'h22);

    chk("pre_rst_write_back", 32'(write_back), 32'h1);
    #2;
    idle();
    rst = 1'b0;
    #1;
    chk("mid_rst_write_back", 32'(write_back), 32'h0);
    chk("mid_rst_dest_wb",    32'(dest_wb),    32'h0);
    chk("mid_rst_result_wb",  result_wb,       32'h0);
    chk("mid_rst_addr_err",   32'(addr_err),   32'h0);
    @(negedge clk);
    rst = 1'b1;
    issue(0, 1, 1, 0, 32'd1032, 32'h0,        4'd13, 1, 4'd13, 32'h5A5A5A5A);
    issue(0, 0, 0, 1, 32'd1024, 32'hDEADBEEF, 4'd0, 0, 4'd0,  32'h400);
    issue(0, 1, 0, 0, 32'h2A,   32'h0,        4'd3, 1, 4'd3,  32'h2A);
    issue(0, 1, 1, 0, 32'd1024, 32'h0,        4'd12, 1, 4'd12, 32'hDEADBEEF);
    chk("post_rst_addr_err", 32'(addr_err), 32'h0);

    idle();
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the ARM-subset pipeline.
- Takes EX/MEM register outputs, performs data-memory load/store, and registers the result.
- Drives the write-back triplet (write_back, dest_wb, result_wb) into the ID stage register-file write port.
- Exposes MEM-stage dest/wb_enable so the hazard unit can generate the ID-stage hazard input.

Parameters:
- DEPTH, 64, data-memory size in 32-bit words (power of two).
- BASE_ADDR, 1024, byte address mapped to word 0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- freeze  input  1  hold MEM/WB register and suppress stores.
- wb_en_in  input  1  EX/MEM write-back enable.
- mem_read_in  input  1  EX/MEM load.
- mem_write_in  input  1  EX/MEM store.
- alu_result  input  32  effective address, or ALU result for non-memory ops.
- val_rm_in  input  32  store data.
- dest_in  input  4  destination register.
- wb_en_mem  output  1  = wb_en_in, combinational, for the hazard unit.
- dest_mem  output  4  = dest_in, combinational, for the hazard unit.
- write_back  output  1  registered write-back enable to ID.
- dest_wb  output  4  registered destination to ID.
- result_wb  output  32  write-back data to ID.
- addr_err  output  1  sticky out-of-range access flag.

Behaviour:
- Word index = (alu_result − BASE_ADDR) >> 2. alu_result[1:0] is ignored (no misalignment trap).
- In range means BASE_ADDR ≤ alu_result < BASE_ADDR + 4·DEPTH. Compare on the full 32 bits; no wrap-around.
- Store: on a rising edge with mem_write_in=1, freeze=0 and the address in range, mem[index] ← val_rm_in.
- Store out of range: no write; addr_err set on that edge.
- Load, synchronous read: on an edge with freeze=0, mem_q ← mem[index] if in range, else 0.
- Load out of range: addr_err set when mem_read_in=1.
- Read and write of the same word in the same cycle: mem_q receives the OLD contents (read-before-write).
- mem_read_in and mem_write_in both 1: treat as a store. mem_q still captures old data; rd_q is forced to 0.
- MEM/WB register: on an edge with freeze=0 it captures:
  - wb_q ← wb_en_in
  - rd_q ← mem_read_in & ~mem_write_in
  - alu_q ← alu_result
  - dest_q ← dest_in
- freeze=1: all MEM/WB fields and mem_q hold; no store; addr_err does not update.
- Outputs:
  - write_back = wb_q
  - dest_wb = dest_q
  - result_wb = rd_q ? mem_q : alu_q (combinational mux after the registers)
- Latency: one cycle from MEM inputs to write-back outputs, for both loads and ALU ops.
- Reset (rst=0, asynchronous):
  - wb_q, rd_q, alu_q, dest_q, mem_q, addr_err all cleared immediately.
  - Hence write_back=0, dest_wb=0, result_wb=0, addr_err=0.
  - Memory array is not reset; contents are retained through reset.
  - A store coinciding with reset assertion is not performed.
- Reset release: first capture is on the first rising edge with rst=1.
- addr_err clears only on reset.
- wb_en_mem and dest_mem are pure pass-through and unaffected by freeze or reset.

Test Plan:
- Reset mid-operation:
  - Stimulus: assert rst=0 asynchronously mid-cycle while write_back=1.
  - Response: write_back, dest_wb, result_wb and addr_err go to 0 before the next edge.
  - Stimulus: release reset; store to 1024, value 0xDEADBEEF; later load 1024.
  - Response: returns 0xDEADBEEF one cycle after the load.
- Store then load:
  - Stimulus: store 0x12345678 to 1028 (wb_en=0), then load 1028 with dest=5, wb_en=1.
  - Response: next cycle write_back=1, dest_wb=5, result_wb=0x12345678.
- ALU pass-through:
  - Stimulus: alu_result=0x0000002A, wb_en=1, dest=3, no mem op.
  - Response: next cycle result_wb=0x2A, dest_wb=3, write_back=1.
- Boundary with DEPTH=64:
  - Stimulus: load 1024+252 (last word).
  - Response: valid data; addr_err stays 0.
  - Stimulus: store to 1280, then load 1020.
  - Response: no write; load result_wb=0; addr_err=1 and stays 1.
- Freeze:
  - Stimulus: hold freeze=1 for 3 cycles while presenting a store to 1032 and a new ALU op.
  - Response: outputs unchanged, mem[2] unchanged.
  - Stimulus: freeze=0.
  - Response: store commits and outputs update next edge.
- Same-word read/write:
  - Stimulus: mem[0]=0x11; present load and store (0x22) to 1024 in one cycle.
  - Response: mem_q=0x11, rd_q=0, mem[0]=0x22, and result_wb=alu_q (0x400) next cycle.
